// File: rtl/ca_epoch_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : ca_epoch_scheduler
// Brief   : Seed / run / migrate sequencer for a ring of 2D binary CA islands.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module ca_epoch_scheduler #(
  parameter int GenWidth   = 8,
  parameter int EpochWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  abort,
  input  logic [GenWidth-1:0]   gens,
  input  logic [EpochWidth-1:0] epochs,
  output logic                  ca_load,
  output logic                  ca_ce,
  output logic                  migrate,
  output logic                  busy,
  output logic                  done,
  output logic [GenWidth-1:0]   gen,
  output logic [EpochWidth-1:0] epoch
);

  localparam logic [GenWidth-1:0]   c_GEN_ONE   = GenWidth'(1);
  localparam logic [EpochWidth-1:0] c_EPOCH_ONE = EpochWidth'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_RUN     = 3'd2,
    S_MIGRATE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GenWidth-1:0]   r_gen,   w_gen_nxt;
  logic [EpochWidth-1:0] r_epoch, w_epoch_nxt;
  logic [GenWidth-1:0]   r_gmax,  w_gmax_nxt;
  logic [EpochWidth-1:0] r_emax,  w_emax_nxt;
  logic                  r_load;
  logic                  r_mig;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_run;

  always_comb begin
    w_state_nxt = r_state;
    w_gen_nxt   = r_gen;
    w_epoch_nxt = r_epoch;
    w_gmax_nxt  = r_gmax;
    w_emax_nxt  = r_emax;
    case (r_state)
      S_IDLE: begin
        w_gen_nxt   = '0;
        w_epoch_nxt = '0;
        if (start) begin
          // Stored as G-1 / E-1 so that a zero setting behaves as one.
          w_gmax_nxt  = (gens == '0)   ? '0 : gens - c_GEN_ONE;
          w_emax_nxt  = (epochs == '0) ? '0 : epochs - c_EPOCH_ONE;
          w_state_nxt = S_SEED;
        end
      end
      S_SEED: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!hold) begin
          if (r_gen == r_gmax) begin
            w_state_nxt = (r_epoch == r_emax) ? S_FINISH : S_MIGRATE;
          end else begin
            w_gen_nxt = r_gen + c_GEN_ONE;
          end
        end
      end
      S_MIGRATE: begin
        w_gen_nxt   = '0;
        w_epoch_nxt = r_epoch + c_EPOCH_ONE;
        w_state_nxt = S_RUN;
      end
      S_FINISH: begin
        w_gen_nxt   = '0;
        w_epoch_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gen_nxt   = '0;
        w_epoch_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_gen_nxt   = '0;
      w_epoch_nxt = '0;
      w_state_nxt = S_IDLE;
    end
  end

  // Strobes are decoded from the next state so they appear registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gen   <= '0;
      r_epoch <= '0;
      r_gmax  <= '0;
      r_emax  <= '0;
      r_load  <= 1'b0;
      r_mig   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gen   <= w_gen_nxt;
      r_epoch <= w_epoch_nxt;
      r_gmax  <= w_gmax_nxt;
      r_emax  <= w_emax_nxt;
      r_load  <= (w_state_nxt == S_SEED) || (w_state_nxt == S_MIGRATE);
      r_mig   <= (w_state_nxt == S_MIGRATE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_FINISH);
      r_run   <= (w_state_nxt == S_RUN);
    end
  end

  // hold gates the enable in the same cycle it is presented.
  assign ca_ce   = r_run & ~hold;
  assign ca_load = r_load;
  assign migrate = r_mig;
  assign busy    = r_busy;
  assign done    = r_done;
  assign gen     = r_gen;
  assign epoch   = r_epoch;

endmodule
`default_nettype wire
